// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2-read/1-write register file and its clear engine.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_AW    = $clog2(DEF_DEPTH);

  typedef logic [0:0] state_t;
  localparam state_t IDLE     = 1'b0;
  localparam state_t CLEARING = 1'b1;

  typedef logic [DEF_AW-1:0] def_addr_t;

  function automatic int unsigned addrWidth(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential-clear engine: walks every entry once, one per cycle, after a Clear request.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW    = addrWidth(DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Clear,
  output logic          Busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // Clear requests are only honoured from IDLE, so a second pulse cannot restart the sweep.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (Clear) begin
          state_d = CLEARING;
          cnt_d   = '0;
        end
      end
      CLEARING: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Busy     = (state_q == CLEARING);
  assign clr_we   = Busy;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised register file, one write port and two registered read ports, with hardware clear.
// Define REGFILE_BYPASS_EN to forward same-cycle writes and clears to the read ports.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter  int unsigned       WIDTH     = DEF_WIDTH,
  parameter  int unsigned       DEPTH     = DEF_DEPTH,
  parameter  logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int unsigned       AW        = addrWidth(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             WrEn,
  input  logic [AW-1:0]    WrAddr,
  input  logic [WIDTH-1:0] WrData,
  input  logic [AW-1:0]    RdAddrA,
  output logic [WIDTH-1:0] RdDataA,
  input  logic [AW-1:0]    RdAddrB,
  output logic [WIDTH-1:0] RdDataB,
  input  logic             Clear,
  output logic             Busy
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdDataA_q, rdDataA_d;
  logic [WIDTH-1:0] rdDataB_q, rdDataB_d;
  logic             clrWe;
  logic [AW-1:0]    clrAddr;
  logic             wrAccept;

  regfile_clear_fsm #(
    .DEPTH (DEPTH)
  ) u_clear_fsm (
    .Clk      (Clk),
    .Reset    (Reset),
    .Clear    (Clear),
    .Busy     (Busy),
    .clr_we   (clrWe),
    .clr_addr (clrAddr)
  );

  // A Clear in the same cycle wins over the write, as does a running clear.
  assign wrAccept = WrEn && !Busy && !Clear && ({1'b0, WrAddr} < DEPTH_W);

  function automatic logic [WIDTH-1:0] readMux(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] data;
    data = '0;
    if ({1'b0, addr} < DEPTH_W) begin
      data = mem_q[addr];
    end
`ifdef REGFILE_BYPASS_EN
    if (wrAccept && (WrAddr == addr)) begin
      data = WrData;
    end
    if (clrWe && (clrAddr == addr)) begin
      data = RESET_VAL;
    end
`endif
    return data;
  endfunction

  always_comb begin
    rdDataA_d = readMux(RdAddrA);
    rdDataB_d = readMux(RdAddrB);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else if (clrWe) begin
      mem_q[clrAddr] <= RESET_VAL;
    end else if (wrAccept) begin
      mem_q[WrAddr] <= WrData;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rdDataA_q <= '0;
      rdDataB_q <= '0;
    end else begin
      rdDataA_q <= rdDataA_d;
      rdDataB_q <= rdDataB_d;
    end
  end

  assign RdDataA = rdDataA_q;
  assign RdDataB = rdDataB_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed, table-driven bench for regfile_2r1w: default 32x16 instance plus an 8x12 instance.
module tb_regfile_2r1w;

  typedef struct {
    logic [3:0]  rdA;
    logic [3:0]  rdB;
    logic [31:0] expA;
    logic [31:0] expB;
  } vec_t;

  logic        Clk;
  logic        Reset;
  logic        WrEn;
  logic [3:0]  WrAddr;
  logic [31:0] WrData;
  logic [3:0]  RdAddrA;
  logic [31:0] RdDataA;
  logic [3:0]  RdAddrB;
  logic [31:0] RdDataB;
  logic        Clear;
  logic        Busy;

  logic        sReset;
  logic        sWrEn;
  logic [3:0]  sWrAddr;
  logic [7:0]  sWrData;
  logic [3:0]  sRdAddrA;
  logic [7:0]  sRdDataA;
  logic [3:0]  sRdAddrB;
  logic [7:0]  sRdDataB;
  logic        sClear;
  logic        sBusy;

  int checkCount = 0;
  int errorCount = 0;

  regfile_2r1w dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .WrEn    (WrEn),
    .WrAddr  (WrAddr),
    .WrData  (WrData),
    .RdAddrA (RdAddrA),
    .RdDataA (RdDataA),
    .RdAddrB (RdAddrB),
    .RdDataB (RdDataB),
    .Clear   (Clear),
    .Busy    (Busy)
  );

  regfile_2r1w #(
    .WIDTH (8),
    .DEPTH (12)
  ) dutSmall (
    .Clk     (Clk),
    .Reset   (sReset),
    .WrEn    (sWrEn),
    .WrAddr  (sWrAddr),
    .WrData  (sWrData),
    .RdAddrA (sRdAddrA),
    .RdDataA (sRdDataA),
    .RdAddrB (sRdAddrB),
    .RdDataB (sRdDataB),
    .Clear   (sClear),
    .Busy    (sBusy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    RdAddrA = v.rdA;
    RdAddrB = v.rdB;
    @(negedge Clk);
    checkOutput($sformatf("readA[%0d]", v.rdA), RdDataA, v.expA);
    checkOutput($sformatf("readB[%0d]", v.rdB), RdDataB, v.expB);
  endtask

  task automatic writeReg(input logic [3:0] addr, input logic [31:0] data);
    WrEn   = 1'b1;
    WrAddr = addr;
    WrData = data;
    @(negedge Clk);
    WrEn   = 1'b0;
  endtask

  task automatic readAllExpect(input logic [31:0] exp, input string tag);
    vec_t v;
    for (int k = 0; k < 16; k++) begin
      v.rdA  = 4'(k);
      v.rdB  = 4'(15 - k);
      v.expA = exp;
      v.expB = exp;
      RdAddrA = v.rdA;
      RdAddrB = v.rdB;
      @(negedge Clk);
      checkOutput($sformatf("%s A[%0d]", tag, k), RdDataA, v.expA);
      checkOutput($sformatf("%s B[%0d]", tag, 15 - k), RdDataB, v.expB);
    end
  endtask

  // Counts Busy cycles from the current negedge; optional mid-clear actions keyed by cycle number.
  task automatic runClear(input int resetAt, input int writeAt, input int clearAgainAt,
                          input bit probe, output int busyCnt);
    int guard;
    busyCnt = 0;
    guard   = 0;
    while (Busy && guard < 64) begin
      busyCnt++;
      guard++;
      if (busyCnt == resetAt) begin
        Reset = 1'b0;
        #1;
        checkOutput("midClearResetBusy", {31'd0, Busy}, 32'd0);
        checkOutput("midClearResetRdA", RdDataA, 32'd0);
        checkOutput("midClearResetRdB", RdDataB, 32'd0);
        break;
      end
      if (probe && busyCnt == 2) begin
        checkOutput("clearMixA15", RdDataA, 32'd16);
        checkOutput("clearMixB1", RdDataB, 32'd2);
      end
      if (probe && busyCnt == 1) begin
        RdAddrA = 4'd15;
        RdAddrB = 4'd1;
      end
      if (busyCnt == writeAt) begin
        WrEn   = 1'b1;
        WrAddr = 4'd3;
        WrData = 32'h77;
      end
      if (busyCnt == clearAgainAt) begin
        Clear = 1'b1;
      end
      @(negedge Clk);
      WrEn  = 1'b0;
      Clear = 1'b0;
    end
  endtask

  task automatic pulseClear(input bit withWrite);
    Clear = 1'b1;
    if (withWrite) begin
      WrEn   = 1'b1;
      WrAddr = 4'd2;
      WrData = 32'h99;
    end
    @(negedge Clk);
    Clear = 1'b0;
    WrEn  = 1'b0;
    checkOutput("busyRise", {31'd0, Busy}, 32'd1);
  endtask

  vec_t vecs[16];
  int   busyCnt;
  int   guard;

  initial begin
    Reset = 1'b0;  sReset = 1'b0;
    WrEn = 1'b0;   WrAddr = '0;  WrData = '0;
    RdAddrA = '0;  RdAddrB = '0; Clear = 1'b0;
    sWrEn = 1'b0;  sWrAddr = '0; sWrData = '0;
    sRdAddrA = '0; sRdAddrB = '0; sClear = 1'b0;

    for (int k = 0; k < 16; k++) begin
      vecs[k].rdA  = 4'(k);
      vecs[k].rdB  = 4'(15 - k);
      vecs[k].expA = 32'(k + 1);
      vecs[k].expB = 32'(16 - k);
    end

    // Reset held for two cycles, then released.
    @(negedge Clk);
    @(negedge Clk);
    checkOutput("resetBusy", {31'd0, Busy}, 32'd0);
    checkOutput("resetRdA", RdDataA, 32'd0);
    checkOutput("resetSmallRdA", {24'd0, sRdDataA}, 32'd0);
    Reset  = 1'b1;
    sReset = 1'b1;
    readAllExpect(32'd0, "postReset");
    checkOutput("postResetBusy", {31'd0, Busy}, 32'd0);

    // Fill every entry with k+1, then read back crosswise from the table.
    for (int k = 0; k < 16; k++) begin
      writeReg(4'(k), 32'(k + 1));
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
    end

    // Clear sweep with a late dropped write and an early mixed read.
    pulseClear(1'b0);
    runClear(0, 10, 0, 1'b1, busyCnt);
    checkOutput("clearBusyCycles", 32'(busyCnt), 32'd16);
    checkOutput("clearBusyFell", {31'd0, Busy}, 32'd0);
    readAllExpect(32'd0, "afterClear");

    // Clear beats a same-cycle write; a second Clear while busy does not restart.
    writeReg(4'd2, 32'h5);
    pulseClear(1'b1);
    runClear(0, 0, 5, 1'b0, busyCnt);
    checkOutput("reclearBusyCycles", 32'(busyCnt), 32'd16);
    RdAddrA = 4'd2;
    @(negedge Clk);
    checkOutput("clearWinsMem2", RdDataA, 32'd0);

    // Same-address write and read in one cycle.
    writeReg(4'd5, 32'h55);
    WrEn = 1'b1; WrAddr = 4'd5; WrData = 32'hAA; RdAddrA = 4'd5;
    @(negedge Clk);
    WrEn = 1'b0;
`ifdef REGFILE_BYPASS_EN
    checkOutput("sameCycleRead", RdDataA, 32'hAA);
`else
    checkOutput("sameCycleRead", RdDataA, 32'h55);
`endif
    @(negedge Clk);
    checkOutput("nextCycleRead", RdDataA, 32'hAA);

    // Reset during the eighth cycle of a clear must wipe untouched entries too.
    writeReg(4'd12, 32'hC);
    writeReg(4'd15, 32'hF);
    pulseClear(1'b0);
    runClear(8, 0, 0, 1'b0, busyCnt);
    checkOutput("resetAtCycle", 32'(busyCnt), 32'd8);
    @(negedge Clk);
    Reset = 1'b1;
    checkOutput("afterResetBusy", {31'd0, Busy}, 32'd0);
    readAllExpect(32'd0, "afterMidReset");
    checkOutput("afterResetBusyStill", {31'd0, Busy}, 32'd0);

    // 8x12 instance: last valid entry, out-of-range write and read, 12-cycle clear.
    sWrEn = 1'b1; sWrAddr = 4'd11; sWrData = 8'hFF;
    @(negedge Clk);
    sWrEn = 1'b1; sWrAddr = 4'd13; sWrData = 8'h3C;
    sRdAddrA = 4'd11; sRdAddrB = 4'd13;
    @(negedge Clk);
    sWrEn = 1'b0;
    checkOutput("smallRead11", {24'd0, sRdDataA}, 32'hFF);
    checkOutput("smallRead13Early", {24'd0, sRdDataB}, 32'd0);
    @(negedge Clk);
    checkOutput("smallRead13", {24'd0, sRdDataB}, 32'd0);
    sRdAddrA = 4'd5;
    @(negedge Clk);
    checkOutput("smallRead5", {24'd0, sRdDataA}, 32'd0);

    sClear = 1'b1;
    @(negedge Clk);
    sClear = 1'b0;
    busyCnt = 0;
    guard   = 0;
    while (sBusy && guard < 64) begin
      busyCnt++;
      guard++;
      @(negedge Clk);
    end
    checkOutput("smallBusyCycles", 32'(busyCnt), 32'd12);
    sRdAddrA = 4'd11;
    @(negedge Clk);
    checkOutput("smallClearedRead11", {24'd0, sRdDataA}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
